// File: rtl/uart_tx_serializer.sv
// UART 8N1/8N2 transmit serializer: accepts one byte per XMitGo while idle and shifts it out LSB first on TxD.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       XMitGo,
    input  logic [7:0] TxData,
    output logic       TxEmpty,
    output logic       TxD,
    output logic       TxDone
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_d, empty_d, done_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // State and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            TxD     <= 1'b1;
            TxEmpty <= 1'b1;
            TxDone  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            TxD     <= txd_d;
            TxEmpty <= empty_d;
            TxDone  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; outputs are derived from the next state so they line up with it
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = 1'b1;
        empty_d = 1'b0;
        done_d  = 1'b0;
        bit_end = (cnt_q == CNT_LAST);
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (XMitGo) begin
                    shift_d = TxData;
                    idx_d   = '0;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^TxData;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // idx_q counts stop bits here
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE:    empty_d = 1'b1;
            START:   txd_d   = 1'b0;
            DATA:    txd_d   = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d   = par_d;
`endif
            STOP:    done_d  = (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
            default: txd_d   = 1'b1;
        endcase
    end

endmodule
